fibo_seq_ctrl: RTL
==================

Name: fibo_seq_ctrl

Overview:
Instruction sequencer for the Fibonacci datapath. It fetches 7-bit instruction words {opcode[2:0], operand1[1:0], operand2[1:0]} from a small synchronous instruction ROM and presents them to the FSM_DECO decoder. It paces each instruction through fetch/load/execute/write-back and repeats the program body a programmable number of iterations. It sits between the top-level start/done interface and the decoder, register file and ALU.

Parameters:
PC_W, 4, instruction address width; program length is up to 2^PC_W words.
CNT_W, 8, iteration counter width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request to run the program; sampled in IDLE only.
abort  in  1  synchronous abort; returns to IDLE without done.
iter_count  in  CNT_W  number of program passes; sampled on accepted start.
prog_last  in  PC_W  address of the last instruction; sampled on accepted start.
imem_rd  out  1  ROM read strobe.
imem_addr  out  PC_W  ROM address; equals pc.
imem_data  in  7  ROM word; valid the cycle after imem_rd.
dec_opcode  out  3  to decoder opcode (IR[6:4]).
dec_operand1  out  2  to decoder operand1 (IR[3:2]).
dec_operand2  out  2  to decoder operand2 (IR[1:0]).
wb_en  out  1  write-back strobe; datapath ANDs it with decoder wrt_en.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
iter_left  out  CNT_W  remaining passes including the current one.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc, IR, iter_left, last_q all 0.
  - imem_rd, wb_en, busy and done are 0; dec_* outputs are 0.
  - All outputs take these values immediately, without waiting for a clock edge.
- States: IDLE, FETCH, LOAD, EXEC, WB, DONE. Encoding is binary, 3 bits.
- IDLE:
  - start=1 latches iter_count into iter_left and prog_last into last_q, and clears pc to 0.
  - Next state is FETCH, or DONE if iter_count==0.
  - start is ignored in every other state.
- FETCH: imem_rd=1, imem_addr=pc. Next state is LOAD.
- LOAD: IR<=imem_data. Next state is EXEC.
- EXEC:
  - dec_* outputs are driven from IR; they stay stable from LOAD+1 through WB.
  - wb_en=0. Next state is WB.
- WB: wb_en=1 for exactly this cycle. Next state is chosen as follows:
  - pc!=last_q: pc<=pc+1, go to FETCH.
  - pc==last_q and iter_left>1: pc<=0, iter_left<=iter_left-1, go to FETCH.
  - pc==last_q and iter_left==1: iter_left<=0, go to DONE.
- DONE: done=1 for one cycle, busy=1. Next state is IDLE.
- pc arithmetic:
  - pc never wraps through the +1 path.
  - When last_q = 2^PC_W-1, the final instruction is followed by pc<=0 only via the iteration path.
- Timing: each instruction takes exactly 4 cycles. With start accepted at edge k, L=last_q+1 instructions and n iterations:
  - the first FETCH occupies cycle k+1;
  - WB of instruction j (0-based, counted across all iterations) occurs in cycle k+4+4j;
  - done is high in cycle k+1+4·L·n.
  - For n=0, done is high in cycle k+1 and imem_rd is never asserted.
- abort:
  - Has priority over every transition.
  - In any non-IDLE state, next state is IDLE.
  - wb_en is forced to 0 in the cycle abort is high.
  - done is not pulsed; pc and iter_left hold; IR holds.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins and start is dropped.
- Changes to iter_count or prog_last during a run have no effect.

Decomposition:
- Shared include/package fibo_defs holds:
  - state encodings (S_IDLE..S_DONE);
  - INSTR_W=7;
  - field positions OPC_MSB/LSB, OP1_MSB/LSB, OP2_MSB/LSB;
  - OPC_W=3, ADDR_W=2.
  FSM_DECO uses the same field constants.
- No sub-module is required. pc and the iteration counter stay inline with the state register.

Test Plan:
- Two-instruction loop: ROM[0]=7'b000_00_01, ROM[1]=7'b001_01_00, prog_last=1, iter_count=3, start at cycle 0.
  - Expect 6 wb_en pulses at cycles 4, 8, …, 24.
  - Expect dec_opcode alternating 000/001 with the matching operands.
  - Expect done in cycle 25 only; iter_left steps 3, 2, 1, 0.
- iter_count=0: start → done in cycle 1; imem_rd and wb_en never asserted; busy high only in cycle 1.
- Full address range: prog_last=15, iter_count=1, ROM[i]={i[2:0], i[1:0], 2'b11}.
  - Expect imem_addr 0..15 in order with no refetch of address 0.
  - Expect done 65 cycles after start.
- Start while busy: second start pulse at cycle 6 of the first scenario → no change in pc, iter_left or done timing.
- Abort in EXEC of instruction 1 (cycle 7): wb_en stays 0 at cycle 8, state is IDLE at cycle 8, done never asserted. A following start runs normally from pc=0.
- Async reset: drive rst_n low mid-LOAD (between clock edges).
  - Expect busy, imem_rd and wb_en to be 0 and dec_* to be 0 immediately.
  - After release, start reproduces the first scenario's timing.

Source files
------------

// File: rtl/fibo_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci instruction sequencer and its decoder:
// state encodings, instruction word layout and field extraction helpers.
package fibo_seq_ctrl_pkg;

   localparam int INSTR_W = 7;
   localparam int OPC_W   = 3;
   localparam int ADDR_W  = 2;

   localparam int OPC_MSB = 6;
   localparam int OPC_LSB = 4;
   localparam int OP1_MSB = 3;
   localparam int OP1_LSB = 2;
   localparam int OP2_MSB = 1;
   localparam int OP2_LSB = 0;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Field extractors shared with FSM_DECO so both sides agree on the layout.
   function automatic logic [OPC_W-1:0] instrOpcode(input logic [INSTR_W-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [ADDR_W-1:0] instrOperand1(input logic [INSTR_W-1:0] instr);
      return instr[OP1_MSB:OP1_LSB];
   endfunction

   function automatic logic [ADDR_W-1:0] instrOperand2(input logic [INSTR_W-1:0] instr);
      return instr[OP2_MSB:OP2_LSB];
   endfunction

endpackage

// File: rtl/fibo_seq_ctrl_if.sv
// Bundle of the sequencer's control, instruction-memory and decoder signals.
// The slave modport is the sequencer; master is the surrounding datapath/host.
interface fibo_seq_ctrl_if #(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
);
   import fibo_seq_ctrl_pkg::*;

   logic                 start;
   logic                 abort;
   logic [CNT_W-1:0]     iter_count;
   logic [PC_W-1:0]      prog_last;

   logic                 imem_rd;
   logic [PC_W-1:0]      imem_addr;
   logic [INSTR_W-1:0]   imem_data;

   logic [OPC_W-1:0]     dec_opcode;
   logic [ADDR_W-1:0]    dec_operand1;
   logic [ADDR_W-1:0]    dec_operand2;
   logic                 wb_en;

   logic                 busy;
   logic                 done;
   logic [CNT_W-1:0]     iter_left;

   modport master (
      output start, abort, iter_count, prog_last, imem_data,
      input  imem_rd, imem_addr, dec_opcode, dec_operand1, dec_operand2,
      input  wb_en, busy, done, iter_left
   );

   modport slave (
      input  start, abort, iter_count, prog_last, imem_data,
      output imem_rd, imem_addr, dec_opcode, dec_operand1, dec_operand2,
      output wb_en, busy, done, iter_left
   );

endinterface

// File: rtl/fibo_seq_ctrl.sv
// Instruction sequencer: fetches words from the ROM, presents them to the decoder
// and paces fetch/load/execute/write-back, repeating the program body n times.
module fibo_seq_ctrl
   import fibo_seq_ctrl_pkg::*;
#(
   parameter int PC_W  = 4,
   parameter int CNT_W = 8
)(
   input logic           clk,
   input logic           rst_n,
   fibo_seq_ctrl_if.slave bus
);

   logic [2:0]         r_state;
   logic [2:0]         w_nextState;
   logic [PC_W-1:0]    r_pc;
   logic [PC_W-1:0]    r_lastQ;
   logic [CNT_W-1:0]   r_iterLeft;
   logic [INSTR_W-1:0] r_ir;

   logic w_abortRun;
   logic w_accept;
   logic w_pcIsLast;
   logic w_morePasses;

   // abort only matters once a run is in progress; in IDLE it merely masks start
   assign w_abortRun   = bus.abort && (r_state != S_IDLE);
   assign w_accept     = (r_state == S_IDLE) && bus.start && !bus.abort;
   assign w_pcIsLast   = (r_pc == r_lastQ);
   assign w_morePasses = (r_iterLeft > CNT_W'(1));

   always_comb begin
      w_nextState = r_state;
      if (w_abortRun) begin
         w_nextState = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_nextState = (bus.iter_count == '0) ? S_DONE : S_FETCH;
            S_FETCH: w_nextState = S_LOAD;
            S_LOAD:  w_nextState = S_EXEC;
            S_EXEC:  w_nextState = S_WB;
            S_WB:    w_nextState = (w_pcIsLast && !w_morePasses) ? S_DONE : S_FETCH;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // pc only advances through +1 up to last_q, so it can never wrap on that path;
   // returning to 0 happens solely when another pass begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= '0;
         r_lastQ    <= '0;
         r_iterLeft <= '0;
         r_ir       <= '0;
      end else if (!w_abortRun) begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_iterLeft <= bus.iter_count;
                  r_lastQ    <= bus.prog_last;
                  r_pc       <= '0;
               end
            end
            S_LOAD: begin
               r_ir <= bus.imem_data;
            end
            S_WB: begin
               if (!w_pcIsLast) begin
                  r_pc <= r_pc + PC_W'(1);
               end else if (w_morePasses) begin
                  r_pc       <= '0;
                  r_iterLeft <= r_iterLeft - CNT_W'(1);
               end else begin
                  r_iterLeft <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode straight from registers so reset reaches them without a clock.
   assign bus.imem_rd      = (r_state == S_FETCH);
   assign bus.imem_addr    = r_pc;
   assign bus.dec_opcode   = instrOpcode(r_ir);
   assign bus.dec_operand1 = instrOperand1(r_ir);
   assign bus.dec_operand2 = instrOperand2(r_ir);
   assign bus.wb_en        = (r_state == S_WB) && !bus.abort;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE);
   assign bus.iter_left    = r_iterLeft;

endmodule
